// File: rtl/mem_bus_responder.sv
// mem_bus_responder: memory-side endpoint of the shared coherence bus.
// It decodes requests from the current bus master, performs the main-memory read
// or write, returns a one-cycle completion message to the controller and drives
// the line that was read onto the bus data lines.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   bus_msg               message code from the current bus master
//   bus_address           line address on the bus
//   bus_data_in           line data from the master (writebacks)
//   req_ready             controller grants memory service of the current request
//   shared_in             OR of snoop-hit lines from peer L1s
//   mem2controller_msg    completion message (MEM_RESP / MEM_RESP_S / MEM_C_RESP)
//   bus_data_out          line data returned to the requester
//   mem_read, mem_write   main-memory strobes, held until mem_valid
//   mem_address           main-memory line address
//   mem_data_out          write data to main memory
//   mem_data_in           read data from main memory
//   mem_valid             main-memory completion
//
// Optional feature, macro MEM_STATS_EN: adds the 32-bit wrapping transaction
// counters stat_reads, stat_writes and stat_coh_wb.

module mem_bus_responder #(
    parameter int unsigned MSG_BITS   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [MSG_BITS-1:0]   bus_msg,
    input  logic [ADDR_WIDTH-1:0] bus_address,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    input  logic                  req_ready,
    input  logic                  shared_in,
    output logic [MSG_BITS-1:0]   mem2controller_msg,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic                  mem_valid
`ifdef MEM_STATS_EN
    ,
    output logic [31:0]           stat_reads,
    output logic [31:0]           stat_writes,
    output logic [31:0]           stat_coh_wb
`endif
);

    localparam logic [MSG_BITS-1:0] NO_REQ     = MSG_BITS'(0);
    localparam logic [MSG_BITS-1:0] R_REQ      = MSG_BITS'(1);
    localparam logic [MSG_BITS-1:0] WB_REQ     = MSG_BITS'(2);
    localparam logic [MSG_BITS-1:0] FLUSH      = MSG_BITS'(3);
    localparam logic [MSG_BITS-1:0] FLUSH_S    = MSG_BITS'(4);
    localparam logic [MSG_BITS-1:0] RFO_BCAST  = MSG_BITS'(6);
    localparam logic [MSG_BITS-1:0] C_WB       = MSG_BITS'(7);
    localparam logic [MSG_BITS-1:0] C_FLUSH    = MSG_BITS'(8);
    localparam logic [MSG_BITS-1:0] MEM_RESP   = MSG_BITS'(10);
    localparam logic [MSG_BITS-1:0] MEM_RESP_S = MSG_BITS'(11);
    localparam logic [MSG_BITS-1:0] MEM_C_RESP = MSG_BITS'(12);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2,
        RESPOND   = 2'd3
    } state_t;

    state_t              state;
    logic [MSG_BITS-1:0] resp_code;  // completion code chosen at accept time
    logic                armed;      // mem_valid only honoured from the second strobe cycle

    // Request classification of the message currently on the bus.
    logic is_coh;
    logic is_rd;
    logic is_wr;
    logic done;

    assign is_coh = (bus_msg == C_WB) || (bus_msg == C_FLUSH);
    assign is_rd  = req_ready && ((bus_msg == R_REQ) || (bus_msg == RFO_BCAST));
    assign is_wr  = req_ready && ((bus_msg == WB_REQ) || (bus_msg == FLUSH) ||
                                  (bus_msg == FLUSH_S));
    assign done   = armed && mem_valid;

    // Responder FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            resp_code          <= NO_REQ;
            armed              <= 1'b0;
            mem2controller_msg <= NO_REQ;
            bus_data_out       <= '0;
            mem_read           <= 1'b0;
            mem_write          <= 1'b0;
            mem_address        <= '0;
            mem_data_out       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mem2controller_msg <= NO_REQ;
                    armed              <= 1'b0;
                    // Coherence writebacks win over any granted request.
                    if (is_coh) begin
                        mem_address  <= bus_address;
                        mem_data_out <= bus_data_in;
                        mem_write    <= 1'b1;
                        resp_code    <= MEM_C_RESP;
                        state        <= MEM_WRITE;
                    end else if (is_rd) begin
                        mem_address <= bus_address;
                        mem_read    <= 1'b1;
                        resp_code   <= ((bus_msg == R_REQ) && shared_in) ? MEM_RESP_S : MEM_RESP;
                        state       <= MEM_READ;
                    end else if (is_wr) begin
                        mem_address  <= bus_address;
                        mem_data_out <= bus_data_in;
                        mem_write    <= 1'b1;
                        resp_code    <= MEM_RESP;
                        state        <= MEM_WRITE;
                    end
                end
                MEM_READ: begin
                    armed <= 1'b1;
                    if (done) begin
                        bus_data_out       <= mem_data_in;
                        mem_read           <= 1'b0;
                        mem2controller_msg <= resp_code;
                        state              <= RESPOND;
                    end
                end
                MEM_WRITE: begin
                    armed <= 1'b1;
                    if (done) begin
                        mem_write          <= 1'b0;
                        mem2controller_msg <= resp_code;
                        state              <= RESPOND;
                    end
                end
                RESPOND: begin
                    mem2controller_msg <= NO_REQ;
                    armed              <= 1'b0;
                    state              <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_STATS_EN
    // Transaction counters, bumped on the edge that enters RESPOND.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_reads  <= 32'd0;
            stat_writes <= 32'd0;
            stat_coh_wb <= 32'd0;
        end else if (done) begin
            if (state == MEM_READ) begin
                stat_reads <= stat_reads + 32'd1;
            end else if (state == MEM_WRITE) begin
                if (resp_code == MEM_C_RESP) begin
                    stat_coh_wb <= stat_coh_wb + 32'd1;
                end else begin
                    stat_writes <= stat_writes + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed and randomized bench for mem_bus_responder.
// Expected responses come from a transaction-level model of the request rules.

module tb_mem_bus_responder;

    localparam int unsigned MSG_BITS   = 4;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 128;

    localparam logic [3:0] NO_REQ     = 4'd0;
    localparam logic [3:0] R_REQ      = 4'd1;
    localparam logic [3:0] WB_REQ     = 4'd2;
    localparam logic [3:0] FLUSH      = 4'd3;
    localparam logic [3:0] FLUSH_S    = 4'd4;
    localparam logic [3:0] RFO_BCAST  = 4'd6;
    localparam logic [3:0] C_WB       = 4'd7;
    localparam logic [3:0] C_FLUSH    = 4'd8;
    localparam logic [3:0] MEM_RESP   = 4'd10;
    localparam logic [3:0] MEM_RESP_S = 4'd11;
    localparam logic [3:0] MEM_C_RESP = 4'd12;

    logic                  clock;
    logic                  reset;
    logic [MSG_BITS-1:0]   bus_msg;
    logic [ADDR_WIDTH-1:0] bus_address;
    logic [DATA_WIDTH-1:0] bus_data_in;
    logic                  req_ready;
    logic                  shared_in;
    logic [MSG_BITS-1:0]   mem2controller_msg;
    logic [DATA_WIDTH-1:0] bus_data_out;
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_valid;
`ifdef MEM_STATS_EN
    logic [31:0]           stat_reads;
    logic [31:0]           stat_writes;
    logic [31:0]           stat_coh_wb;
`endif

    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;
    logic [127:0] exp_bdo;  // model of the last line returned by a read

    mem_bus_responder #(
        .MSG_BITS  (MSG_BITS),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .bus_msg           (bus_msg),
        .bus_address       (bus_address),
        .bus_data_in       (bus_data_in),
        .req_ready         (req_ready),
        .shared_in         (shared_in),
        .mem2controller_msg(mem2controller_msg),
        .bus_data_out      (bus_data_out),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_address       (mem_address),
        .mem_data_out      (mem_data_out),
        .mem_data_in       (mem_data_in),
        .mem_valid         (mem_valid)
`ifdef MEM_STATS_EN
        ,
        .stat_reads        (stat_reads),
        .stat_writes       (stat_writes),
        .stat_coh_wb       (stat_coh_wb)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_bus();
        bus_msg   = NO_REQ;
        req_ready = 1'b0;
        shared_in = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_msg"},  128'(mem2controller_msg), 128'(NO_REQ));
        chk({tag, "_bdo"},  bus_data_out, 128'(0));
        chk({tag, "_rd"},   128'(mem_read), 128'(0));
        chk({tag, "_wr"},   128'(mem_write), 128'(0));
        chk({tag, "_addr"}, 128'(mem_address), 128'(0));
        chk({tag, "_wdat"}, mem_data_out, 128'(0));
    endtask

    // 0: ignored, 1: memory read, 2: granted write, 3: coherence write
    function automatic int kind_of(input logic [3:0] m, input logic rdy);
        if (m == C_WB || m == C_FLUSH) return 3;
        if (!rdy) return 0;
        if (m == R_REQ || m == RFO_BCAST) return 1;
        if (m == WB_REQ || m == FLUSH || m == FLUSH_S) return 2;
        return 0;
    endfunction

    // Present one request and follow it through to the return to IDLE.
    // n is the number of strobe cycles; mem_valid is raised in the last one.
    task automatic txn(input string tag, input logic [3:0] m, input logic rdy, input logic sh,
                       input logic [31:0] a, input logic [127:0] wd, input logic [127:0] rd,
                       input int n);
        int         k;
        logic [3:0] resp;
        k = kind_of(m, rdy);
        if (k == 3)                           resp = MEM_C_RESP;
        else if (k == 1 && m == R_REQ && sh)  resp = MEM_RESP_S;
        else                                  resp = MEM_RESP;
        bus_msg     = m;
        req_ready   = rdy;
        shared_in   = sh;
        bus_address = a;
        bus_data_in = wd;
        step();
        if (k == 0) begin
            idle_bus();
            chk({tag, "_ign_rd"},  128'(mem_read), 128'(0));
            chk({tag, "_ign_wr"},  128'(mem_write), 128'(0));
            chk({tag, "_ign_msg"}, 128'(mem2controller_msg), 128'(NO_REQ));
            return;
        end
        for (int i = 1; i <= n; i++) begin
            chk({tag, "_strb_rd"}, 128'(mem_read), 128'(k == 1));
            chk({tag, "_strb_wr"}, 128'(mem_write), 128'(k != 1));
            chk({tag, "_addr"},    128'(mem_address), 128'(a));
            if (k != 1) chk({tag, "_wdat"}, mem_data_out, wd);
            chk({tag, "_busy_msg"}, 128'(mem2controller_msg), 128'(NO_REQ));
            if (i == n) begin
                idle_bus();
                mem_valid   = 1'b1;
                mem_data_in = rd;
            end else begin
                // Bus activity during a transaction must be ignored.
                bus_msg     = 4'($urandom_range(0, 15));
                req_ready   = 1'($urandom);
                shared_in   = 1'($urandom);
                bus_address = $urandom;
                bus_data_in = {$urandom, $urandom, $urandom, $urandom};
                mem_data_in = {$urandom, $urandom, $urandom, $urandom};
            end
            step();
        end
        mem_valid   = 1'b0;
        mem_data_in = {$urandom, $urandom, $urandom, $urandom};
        if (k == 1) exp_bdo = rd;
        chk({tag, "_resp"},     128'(mem2controller_msg), 128'(resp));
        chk({tag, "_resp_rd"},  128'(mem_read), 128'(0));
        chk({tag, "_resp_wr"},  128'(mem_write), 128'(0));
        chk({tag, "_bdo"},      bus_data_out, exp_bdo);
        step();
        chk({tag, "_after_msg"}, 128'(mem2controller_msg), 128'(NO_REQ));
        chk({tag, "_after_rd"},  128'(mem_read), 128'(0));
        chk({tag, "_after_wr"},  128'(mem_write), 128'(0));
        chk({tag, "_after_bdo"}, bus_data_out, exp_bdo);
    endtask

    initial begin
        logic [3:0]   rm;
        logic [127:0] d1;
        logic [127:0] d2;
        reset       = 1'b1;
        bus_address = '0;
        bus_data_in = '0;
        mem_data_in = '0;
        exp_bdo     = '0;
        idle_bus();
        step();
        step();
        chk_reset_outputs("reset");
        reset = 1'b0;
        step();

        // Plain read, four strobe cycles.
        txn("rreq", R_REQ, 1'b1, 1'b0, 32'h40, 128'h0, {16{8'hA5}}, 4);
        // Shared read and RFO with sharers.
        txn("rreq_sh", R_REQ, 1'b1, 1'b1, 32'h44, 128'h0, 128'hDEAD_BEEF_0000_1111, 2);
        txn("rfo_sh", RFO_BCAST, 1'b1, 1'b1, 32'h48, 128'h0, 128'h5A5A_0000_7777, 3);
        // Granted writeback.
        txn("wbreq", WB_REQ, 1'b1, 1'b0, 32'h80, 128'h1234, 128'h0, 3);
        // Coherence writes bypass req_ready and beat a granted request.
        txn("cflush", C_FLUSH, 1'b0, 1'b0, 32'hC0, 128'hFEED_F00D, 128'h0, 2);
        txn("cwb_prio", C_WB, 1'b1, 1'b1, 32'hC4, 128'hCAFE_0001, 128'h0, 2);

        // Ungranted read stays pending without a strobe.
        bus_msg     = R_REQ;
        req_ready   = 1'b0;
        bus_address = 32'h200;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("nordy_rd", 128'(mem_read), 128'(0));
        end
        txn("rdy_late", R_REQ, 1'b1, 1'b0, 32'h200, 128'h0, 128'h0BAD_CAFE, 2);

        // Reset in the middle of a read aborts it; a late mem_valid is ignored.
        bus_msg     = R_REQ;
        req_ready   = 1'b1;
        bus_address = 32'h300;
        step();
        idle_bus();
        chk("abort_strobe", 128'(mem_read), 128'(1));
        step();
        reset = 1'b1;
        step();
        reset   = 1'b0;
        exp_bdo = '0;
        chk_reset_outputs("abort");
        mem_valid   = 1'b1;
        mem_data_in = {4{32'h1357_9BDF}};
        step();
        mem_valid = 1'b0;
        chk("late_valid_msg", 128'(mem2controller_msg), 128'(NO_REQ));
        chk("late_valid_bdo", bus_data_out, exp_bdo);
        step();
        chk("late_valid_msg2", 128'(mem2controller_msg), 128'(NO_REQ));
        chk("late_valid_rd", 128'(mem_read), 128'(0));

        // Randomized traffic over all codes.
        for (int t = 0; t < 60; t++) begin
            rm = 4'($urandom_range(0, 15));
            d1 = {$urandom, $urandom, $urandom, $urandom};
            d2 = {$urandom, $urandom, $urandom, $urandom};
            txn("rand", rm, 1'($urandom), 1'($urandom), $urandom, d1, d2,
                int'($urandom_range(2, 6)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
